// File: rtl/dmem_pkg.sv
// Shared types and helpers for the wait-stated MEM-stage data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Latched request; addr keeps only the low 32 bits, which covers the
  // word index for any legal DEPTH.
  typedef struct packed {
    logic        we;
    size_e       size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // True when the access cannot be performed: half on an odd byte, word off
  // a word boundary, or the reserved size code.
  function automatic logic misaligned(size_e size, logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      SZ_WORD: return lane != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_ws_if.sv
// Request/response bus between the MEM stage and the data memory.
interface data_memory_ws_if #(parameter int ADDR_W = 32);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              stall;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store mask/shift and load extract/extend.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  assign shifted = rword >> {lane, 3'b000};

  // Store direction: replicate the right-justified data across lanes and
  // enable only the lanes being written.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    be    = 4'b0000;
    wword = 32'h0;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        be    = 4'b1111;
        wword = wdata;
      end
      default: ;
    endcase
  end

  // Load direction: pick the lanes, then sign- or zero-extend.
  always_comb begin
    rdata = 32'h0;
    case (size)
      SZ_BYTE: rdata = is_unsigned ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata = is_unsigned ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      SZ_WORD: rdata = rword;
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_ws.sv
// MEM-stage data memory with byte/half/word access, configurable wait
// states and a valid/ready request handshake.
module data_memory_ws
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  data_memory_ws_if.slave bus
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, live_req, acc_req;
  logic        accept, do_access, do_write, acc_err;
  logic [IDX_W-1:0] idx;
  logic [31:0] words [DEPTH];
  logic [31:0] rword, wword, rdata;
  logic [3:0]  be;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        unused_addr_bits;

  assign live_req = '{we:          bus.req_we,
                      size:        size_e'(bus.req_size),
                      is_unsigned: bus.req_unsigned,
                      addr:        32'(bus.req_addr),
                      wdata:       bus.req_wdata};

  assign bus.req_ready  = !rst && (state_q != ST_WAIT);
  assign accept         = bus.req_valid && bus.req_ready;
  assign bus.stall      = bus.req_valid && !bus.req_ready && !rst;
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  // With no wait states the access happens on the accepting edge itself,
  // so it must use the live bus fields rather than the request register.
  assign acc_req   = (LATENCY == 0) ? live_req : req_q;
  assign do_access = (LATENCY == 0) ? accept
                                    : (state_q == ST_WAIT && cnt_q == 4'd0);
  assign acc_err   = misaligned(acc_req.size, acc_req.addr[1:0]);
  assign do_write  = do_access && acc_req.we && !acc_err;
  assign idx       = acc_req.addr[IDX_W+1:2];
  assign rword     = words[idx];
  assign unused_addr_bits = ^acc_req.addr;

  dmem_lane_align u_align (
    .size        (acc_req.size),
    .lane        (acc_req.addr[1:0]),
    .is_unsigned (acc_req.is_unsigned),
    .wdata       (acc_req.wdata),
    .rword       (rword),
    .be          (be),
    .wword       (wword),
    .rdata       (rdata)
  );

  // Next-state and wait counter: accept starts a transaction from IDLE or
  // RESP; WAIT counts down and moves to RESP at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and request register; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) req_q <= live_req;
    end
  end

  // Response registers, loaded on the edge entering RESP and held after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else if (do_access) begin
      resp_err_q   <= acc_err;
      resp_rdata_q <= (acc_req.we || acc_err) ? 32'h0 : rdata;
    end
  end

  // Storage: one register per word, word i powered up holding i.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [31:0] word_q = 32'(i);

    // Lane-masked write of the addressed word.
    // NOTE: the array has no reset; contents survive rst and only the
    // power-up value applies, which keeps it mappable to block RAM.
    always_ff @(posedge clk) begin
      if (do_write && idx == IDX_W'(i)) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) word_q[8*b +: 8] <= wword[8*b +: 8];
        end
      end
    end

    assign words[i] = word_q;
  end

endmodule

// File: tb/tb_data_memory_ws.sv
// Self-checking bench: one DUT with two wait states, one with none, both
// checked against a byte-array reference model.
module tb_data_memory_ws;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_memory_ws_if #(.ADDR_W(32)) bus2 ();
  data_memory_ws_if #(.ADDR_W(32)) bus0 ();

  data_memory_ws #(.ADDR_W(32), .DEPTH(256), .LATENCY(2)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2)
  );
  data_memory_ws #(.ADDR_W(32), .DEPTH(256), .LATENCY(0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );

  // Shared request fields; sel chooses which DUT sees req_valid and whose
  // outputs are observed (0 = LATENCY 2, 1 = LATENCY 0).
  logic        sel, valid, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ready, resp_valid, err, stall;
  logic [31:0] rdata;

  assign bus2.req_valid = valid && !sel;
  assign bus0.req_valid = valid && sel;
  assign bus2.req_we = we;        assign bus0.req_we = we;
  assign bus2.req_size = size;    assign bus0.req_size = size;
  assign bus2.req_unsigned = uns; assign bus0.req_unsigned = uns;
  assign bus2.req_addr = addr;    assign bus0.req_addr = addr;
  assign bus2.req_wdata = wdata;  assign bus0.req_wdata = wdata;

  assign ready      = sel ? bus0.req_ready  : bus2.req_ready;
  assign resp_valid = sel ? bus0.resp_valid : bus2.resp_valid;
  assign rdata      = sel ? bus0.resp_rdata : bus2.resp_rdata;
  assign err        = sel ? bus0.resp_err   : bus2.resp_err;
  assign stall      = sel ? bus0.stall      : bus2.stall;

  int checks   = 0;
  int failures = 0;

  // Reference memory as little-endian bytes, one image per DUT.
  logic [7:0] refm [2][1024];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_op(input int s, input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a,
                          input logic [31:0] d, output logic e,
                          output logic [31:0] r);
    int n, base;
    logic [31:0] v;
    e = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    r = 32'h0;
    if (e) return;
    n    = 1 << sz;
    base = int'(a[9:0]);
    if (w) begin
      for (int k = 0; k < n; k++) refm[s][base + k] = d[8*k +: 8];
    end else begin
      v = 32'h0;
      for (int k = 0; k < n; k++) v = v | (32'(refm[s][base + k]) << (8 * k));
      if (!u && n < 4 && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
      r = v;
    end
  endtask

  // One complete transaction: handshake, latency, pulse width and data.
  task automatic do_req(input string tag, input logic s, input logic w,
                        input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd);
    logic e_exp;
    logic [31:0] r_exp;
    int k;
    @(posedge clk); #1;
    sel = s; valid = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    k = 0;
    @(negedge clk);
    while (!ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, " accept"}, 32'(ready), 32'd1);
    @(posedge clk); #1;
    valid = 1'b0; addr = $urandom; wdata = $urandom;
    size = 2'($urandom); we = 1'($urandom); uns = 1'($urandom);
    model_op(int'(s), w, sz, u, a, d, e_exp, r_exp);
    k = 0;
    while (!resp_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, " latency"}, 32'(k), s ? 32'd0 : 32'd2);
    check({tag, " err"}, 32'(err), 32'(e_exp));
    check({tag, " rdata"}, rdata, r_exp);
    rd = rdata;
    @(posedge clk); #1;
    check({tag, " pulse"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, m_r;
    logic m_e, w_r;
    logic [1:0] s_r;

    for (int i = 0; i < 256; i++)
      for (int b = 0; b < 4; b++) begin
        refm[0][4*i + b] = 8'(i >> (8 * b));
        refm[1][4*i + b] = 8'(i >> (8 * b));
      end

    sel = 1'b0; valid = 1'b0; we = 1'b0; size = 2'd2; uns = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    rst = 1'b1;

    // Reset values, including stall held low with a request pending.
    repeat (2) @(posedge clk);
    #1 valid = 1'b1;
    #1;
    check("rst ready", 32'(ready), 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst rdata", rdata, 32'h0);
    check("rst err", 32'(err), 32'd0);
    valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    #1 check("post-rst ready", 32'(ready), 32'd1);

    // Basic loads and address wrap.
    do_req("lw_10", 0, 0, 2'd2, 0, 32'h10, 0, r);
    check("lw_10 const", r, 32'h0000_0004);
    do_req("lw_400", 0, 0, 2'd2, 0, 32'h400, 0, r);
    check("lw_400 const", r, 32'h0);

    // Byte store and the three views of it.
    do_req("sb_21", 0, 1, 2'd0, 0, 32'h21, 32'h1234_56AB, r);
    check("sb_21 rdata zero", r, 32'h0);
    do_req("lw_20", 0, 0, 2'd2, 0, 32'h20, 0, r);
    check("lw_20 const", r, 32'h0000_AB08);
    do_req("lb_21", 0, 0, 2'd0, 0, 32'h21, 0, r);
    check("lb_21 const", r, 32'hFFFF_FFAB);
    do_req("lbu_21", 0, 0, 2'd0, 1, 32'h21, 0, r);
    check("lbu_21 const", r, 32'h0000_00AB);

    // Halfword store on the upper half.
    do_req("sh_32", 0, 1, 2'd1, 0, 32'h32, 32'h0000_8001, r);
    do_req("lh_32", 0, 0, 2'd1, 0, 32'h32, 0, r);
    check("lh_32 const", r, 32'hFFFF_8001);
    do_req("lhu_32", 0, 0, 2'd1, 1, 32'h32, 0, r);
    check("lhu_32 const", r, 32'h0000_8001);
    do_req("lw_30", 0, 0, 2'd2, 0, 32'h30, 0, r);
    check("lw_30 const", r, 32'h8001_000C);

    // Errors: misaligned load, misaligned store with no write, bad size.
    do_req("lw_13", 0, 0, 2'd2, 0, 32'h13, 0, r);
    check("lw_13 err const", 32'(err), 32'd1);
    do_req("sw_42", 0, 1, 2'd2, 0, 32'h42, 32'hFFFF_FFFF, r);
    check("sw_42 err const", 32'(err), 32'd1);
    do_req("lw_40", 0, 0, 2'd2, 0, 32'h40, 0, r);
    check("lw_40 const", r, 32'h0000_0010);
    do_req("ill_44", 0, 0, 2'd3, 0, 32'h44, 0, r);
    check("ill_44 err const", 32'(err), 32'd1);

    // Held request with two wait states: one accept every three cycles.
    @(posedge clk); #1;
    sel = 1'b0; valid = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0;
    addr = 32'h10;
    @(negedge clk);
    check("hold idle stall", 32'(stall), 32'd0);
    for (int c = 0; c < 9; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold stall", 32'(stall), (c % 3 != 2) ? 32'd1 : 32'd0);
      check("hold ready", 32'(ready), (c % 3 != 2) ? 32'd0 : 32'd1);
      check("hold resp_valid", 32'(resp_valid), (c % 3 == 2) ? 32'd1 : 32'd0);
      if (c % 3 == 2) check("hold rdata", rdata, 32'h4);
    end
    valid = 1'b0;
    @(posedge clk); #1;
    check("hold end", 32'(resp_valid), 32'd0);

    // No wait states: four back-to-back loads, one response per cycle.
    @(posedge clk); #1;
    sel = 1'b1; valid = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0;
    addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b stall", 32'(stall), 32'd0);
      check("b2b ready", 32'(ready), 32'd1);
      @(posedge clk); #1;
      check("b2b resp_valid", 32'(resp_valid), 32'd1);
      check("b2b rdata", rdata, 32'(i));
      addr = 32'(4 * (i + 1));
      if (i == 3) valid = 1'b0;
    end
    @(posedge clk); #1;
    check("b2b end", 32'(resp_valid), 32'd0);

    // Store then load on consecutive cycles with no wait states.
    @(posedge clk); #1;
    sel = 1'b1; valid = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h8;
    wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    model_op(1, 1, 2'd2, 0, 32'h8, 32'hCAFE_F00D, m_e, m_r);
    we = 1'b0;
    @(posedge clk); #1;
    valid = 1'b0;
    check("raw rdata", rdata, 32'hCAFE_F00D);
    check("raw resp_valid", 32'(resp_valid), 32'd1);

    // Random traffic on words 0..15 with random upper address bits.
    for (int n = 0; n < 60; n++) begin
      w_r = 1'($urandom_range(0, 1));
      s_r = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_req("rnd", 1'(n & 1), w_r, s_r, 1'($urandom_range(0, 1)),
             $urandom & 32'hFFFF_FC3F, $urandom, r);
    end

    // Reset during WAIT drops the pending store and its response.
    do_req("lw_5c", 0, 0, 2'd2, 0, 32'h5C, 0, r);
    check("lw_5c const", r, 32'h0000_0017);
    @(posedge clk); #1;
    sel = 1'b0; valid = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h50;
    wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst resp_valid", 32'(resp_valid), 32'd0);
    check("midrst rdata", rdata, 32'h0);
    check("midrst err", 32'(err), 32'd0);
    check("midrst ready", 32'(ready), 32'd0);
    check("midrst stall", 32'(stall), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("midrst hold", 32'(resp_valid), 32'd0);
    end
    @(negedge clk) rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("postrst no resp", 32'(resp_valid), 32'd0);
    end
    do_req("lw_50", 0, 0, 2'd2, 0, 32'h50, 0, r);
    check("lw_50 const", r, 32'h0000_0014);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
